// File: rtl/sof_mailbox_pkg.sv
// Shared types and helpers for the software/fabric mailbox bridge.
package sof_mailbox_pkg;

  localparam int OVF_CNT_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_COMMIT     = 2'd1;
  localparam state_t ST_WAIT_SPACE = 2'd2;
  localparam state_t ST_ACK        = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sof_cmd_fifo.sv
// First-word-fall-through command FIFO; a push into a full FIFO lands when a pop happens the same cycle.
module sof_cmd_fifo
  import sof_mailbox_pkg::*;
#(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [W-1:0]         push_data,
  input  logic                 pop_ready,
  output logic [W-1:0]         head,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic [clog2(DEPTH):0] level
);
  localparam int PW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop, wr_en;

  assign empty = (level == '0);
  assign full  = (level == (PW+1)'(DEPTH));
  assign valid = !empty;
  assign pop   = valid & pop_ready;
  assign wr_en = push & (!full | pop);
  assign head  = mem[rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            mem[g] <= '0;
      else if (wr_en && wr_ptr == PW'(g))    mem[g] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !pop)      level <= level + (PW+1)'(1);
      else if (!wr_en && pop) level <= level - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/sof_mailbox_bridge.sv
// Software req/ack mailbox: commits a write into a register file and forwards it as a FIFO command.
module sof_mailbox_bridge
  import sof_mailbox_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BLOCKING   = 1
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         sw_req,
  input  logic [31:0]                  sw_addr,
  input  logic [DATA_W-1:0]            sw_data,
  output logic                         hw_ack,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2(NUM_REGS)-1:0]   out_addr,
  output logic [DATA_W-1:0]            out_data,
  output logic [clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [OVF_CNT_W-1:0]         overflow_cnt,
  output logic                         addr_err,
  input  logic                         err_clr
);
  localparam int AW = clog2(NUM_REGS);

  logic [1:0]        rst_sync;
  logic              rst_n;
  state_t            state, state_nx;
  logic [31:0]       stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic [AW-1:0]     stage_idx;
  logic              addr_ok, full, empty, can_accept, push, reg_we, ovf_inc;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset asserts immediately but releases only after two clean edges.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync <= '0;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign stage_idx  = stage_addr[AW-1:0];
  assign addr_ok    = (stage_addr < 32'(NUM_REGS));
  assign can_accept = !full | (out_valid & out_ready);
  assign reg_we     = (state == ST_COMMIT) && addr_ok;
  assign push       = (reg_we || state == ST_WAIT_SPACE) && can_accept;
  assign ovf_inc    = reg_we && !can_accept && (BLOCKING == 0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:       if (sw_req) state_nx = ST_COMMIT;
      ST_COMMIT:     state_nx = (reg_we && !can_accept && BLOCKING != 0) ? ST_WAIT_SPACE : ST_ACK;
      ST_WAIT_SPACE: if (can_accept) state_nx = ST_ACK;
      default:       if (!sw_req) state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hw_ack       <= 1'b0;
      stage_addr   <= '0;
      stage_data   <= '0;
      addr_err     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state  <= state_nx;
      hw_ack <= (state == ST_ACK);
      if (state == ST_IDLE && sw_req) begin
        stage_addr <= sw_addr;
        stage_data <= sw_data;
      end
      // A new error or overflow in the same cycle as err_clr takes priority.
      if (state == ST_COMMIT && !addr_ok) addr_err <= 1'b1;
      else if (err_clr)                   addr_err <= 1'b0;
      if (ovf_inc) begin
        if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + OVF_CNT_W'(1);
      end else if (err_clr) begin
        overflow_cnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n)                               regs[g] <= '0;
      else if (reg_we && stage_idx == AW'(g))   regs[g] <= stage_data;
    end
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  sof_cmd_fifo #(
    .W     (AW + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({stage_idx, stage_data}),
    .pop_ready (out_ready),
    .head      ({out_addr, out_data}),
    .valid     (out_valid),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_sof_mailbox_bridge.sv
// Directed bench: instance 0 blocks on a full FIFO, instance 1 drops and counts overflow.
module tb_sof_mailbox_bridge;
  logic         clk, rst_n;
  logic         req  [2];
  logic [31:0]  addr [2];
  logic [31:0]  data [2];
  logic         rdy  [2];
  logic         clr  [2];
  logic         ack  [2];
  logic [255:0] regs [2];
  logic         ov   [2];
  logic [2:0]   oa   [2];
  logic [31:0]  od   [2];
  logic [2:0]   lvl  [2];
  logic [15:0]  ovc  [2];
  logic         aerr [2];

  int checks = 0;
  int errors = 0;
  logic [255:0] e;

  sof_mailbox_bridge #(.DATA_W(32), .NUM_REGS(8), .FIFO_DEPTH(4), .BLOCKING(1)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_req(req[0]), .sw_addr(addr[0]), .sw_data(data[0]),
    .hw_ack(ack[0]), .regs_flat(regs[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_addr(oa[0]),
    .out_data(od[0]), .fifo_level(lvl[0]), .overflow_cnt(ovc[0]), .addr_err(aerr[0]), .err_clr(clr[0]));

  sof_mailbox_bridge #(.DATA_W(32), .NUM_REGS(8), .FIFO_DEPTH(4), .BLOCKING(0)) dut_d (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_req(req[1]), .sw_addr(addr[1]), .sw_data(data[1]),
    .hw_ack(ack[1]), .regs_flat(regs[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_addr(oa[1]),
    .out_data(od[1]), .fifo_level(lvl[1]), .overflow_cnt(ovc[1]), .addr_err(aerr[1]), .err_clr(clr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int w, input logic [31:0] a, input logic [31:0] d);
    int n;
    req[w] = 1'b1; addr[w] = a; data[w] = d;
    n = 0;
    while (ack[w] !== 1'b1 && n < 20) begin step(); n++; end
    chk("wr_ack_high", ack[w], 1);
    req[w] = 1'b0;
    n = 0;
    while (ack[w] !== 1'b0 && n < 20) begin step(); n++; end
    chk("wr_ack_low", ack[w], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      req[w] = 0; addr[w] = 0; data[w] = 0; rdy[w] = 0; clr[w] = 0;
    end
    repeat (3) step();
    chk("rst_ack", ack[0], 0);
    chk("rst_valid", ov[0], 0);
    chk("rst_level", lvl[0], 0);
    chk("rst_regs", regs[0], 0);
    chk("rst_ovf", ovc[1], 0);
    chk("rst_aerr", aerr[0], 0);
    rst_n = 1'b1;
    repeat (3) step();

    // basic write and latency
    req[0] = 1; addr[0] = 3; data[0] = 32'hDEADBEEF;
    step();
    chk("basic_reg_early", regs[0], 0);
    step();
    e = '0; e[3*32 +: 32] = 32'hDEADBEEF;
    chk("basic_reg", regs[0], e);
    chk("basic_valid", ov[0], 1);
    chk("basic_oaddr", oa[0], 3);
    chk("basic_odata", od[0], 32'hDEADBEEF);
    chk("basic_ack_early", ack[0], 0);
    step();
    chk("basic_ack", ack[0], 1);
    req[0] = 0;
    step();
    chk("basic_ack_hold", ack[0], 1);
    step();
    chk("basic_ack_drop", ack[0], 0);
    rdy[0] = 1; step(); rdy[0] = 0;
    chk("basic_popped", lvl[0], 0);

    // out-of-range addresses, including one whose low bits alias reg 3
    wr(0, 32'd8, 32'd5);
    chk("bad_regs", regs[0], e);
    chk("bad_aerr", aerr[0], 1);
    chk("bad_level", lvl[0], 0);
    clr[0] = 1; step(); clr[0] = 0;
    chk("bad_clr", aerr[0], 0);
    wr(0, 32'h0000_0103, 32'd9);
    chk("bad_hi_regs", regs[0], e);
    chk("bad_hi_aerr", aerr[0], 1);
    clr[0] = 1; step(); clr[0] = 0;

    // blocking mode fills and stalls
    for (int i = 0; i < 4; i++) wr(0, i, 32'h100 + i);
    chk("blk_full", lvl[0], 4);
    req[0] = 1; addr[0] = 4; data[0] = 32'h104;
    step(); step();
    chk("blk_reg4", regs[0][4*32 +: 32], 32'h104);
    step(); step();
    chk("blk_stall_ack", ack[0], 0);
    chk("blk_stall_lvl", lvl[0], 4);
    rdy[0] = 1; step(); rdy[0] = 0;
    chk("blk_pp_lvl", lvl[0], 4);
    chk("blk_head_a", oa[0], 1);
    chk("blk_head_d", od[0], 32'h101);
    step();
    chk("blk_ack", ack[0], 1);
    req[0] = 0; step(); step();
    chk("blk_ack_low", ack[0], 0);

    // full FIFO with a pop during COMMIT: no stall
    req[0] = 1; addr[0] = 5; data[0] = 32'h105;
    step();
    rdy[0] = 1; step(); rdy[0] = 0;
    chk("pp_lvl", lvl[0], 4);
    chk("pp_head", oa[0], 2);
    step();
    chk("pp_ack", ack[0], 1);
    req[0] = 0; step(); step();

    // drain across pointer wrap
    rdy[0] = 1;
    for (int i = 2; i < 6; i++) begin
      chk("drain_a", oa[0], i);
      chk("drain_d", od[0], 32'h100 + i);
      step();
    end
    rdy[0] = 0;
    chk("drain_lvl", lvl[0], 0);
    chk("drain_valid", ov[0], 0);

    // drop mode
    for (int i = 0; i < 6; i++) wr(1, i, 32'h300 + i);
    e = '0;
    for (int i = 0; i < 6; i++) e[i*32 +: 32] = 32'h300 + i;
    chk("drop_lvl", lvl[1], 4);
    chk("drop_ovc", ovc[1], 2);
    chk("drop_regs", regs[1], e);
    chk("drop_head_a", oa[1], 0);
    chk("drop_head_d", od[1], 32'h300);
    clr[1] = 1; step(); clr[1] = 0;
    chk("drop_clr", ovc[1], 0);

    // reset while stalled in WAIT_SPACE
    for (int i = 0; i < 4; i++) wr(0, i, 32'h200 + i);
    req[0] = 1; addr[0] = 7; data[0] = 32'h207;
    step(); step(); step();
    chk("rmt_stall", lvl[0], 4);
    rst_n = 1'b0;
    #1;
    chk("rmt_regs", regs[0], 0);
    chk("rmt_lvl", lvl[0], 0);
    chk("rmt_valid", ov[0], 0);
    chk("rmt_ack", ack[0], 0);
    req[0] = 0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    wr(0, 6, 32'h600);
    e = '0; e[6*32 +: 32] = 32'h600;
    chk("post_regs", regs[0], e);
    chk("post_lvl", lvl[0], 1);
    chk("post_head_a", oa[0], 6);
    chk("post_head_d", od[0], 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sof_mailbox_bridge.md
Name: sof_mailbox_bridge

Overview:
- Parametrised successor to the single-register software/hardware PIO handshake between the Nios software and FPGA fabric.
- Software presents an address word and a data word, then raises a request. The block commits the data into one of NUM_REGS hardware registers and forwards the write as a command through a FIFO to fabric consumers (game/video logic).
- It completes a four-phase req/ack handshake.
- Sits between the system's PIO exports and user logic, in the same clock domain.

Parameters:
- DATA_W, 32, width of data word and of each register
- NUM_REGS, 8, number of hardware registers (power of two, 2..256)
- FIFO_DEPTH, 4, command FIFO entries (power of two, 2..64)
- BLOCKING, 1, 1 = stall handshake while FIFO is full; 0 = drop command and count overflow

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- sw_req  in  1  request level from software PIO (hardware_sig)
- sw_addr  in  32  target register index from software PIO (reg_from_sof)
- sw_data  in  DATA_W  write data from software PIO (data_from_sof)
- hw_ack  out  1  acknowledge level to software PIO (software_sig)
- regs_flat  out  NUM_REGS*DATA_W  register file; reg i occupies bits [i*DATA_W +: DATA_W]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_addr  out  clog2(NUM_REGS)  head register index
- out_data  out  DATA_W  head data
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow_cnt  out  16  dropped commands, saturating at 16'hFFFF
- addr_err  out  1  sticky: an out-of-range address was received
- err_clr  in  1  single-cycle pulse; clears addr_err and overflow_cnt

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE, hw_ack=0, all registers 0, FIFO empty, out_valid=0, fifo_level=0, overflow_cnt=0, addr_err=0.
- FSM states: IDLE, COMMIT, WAIT_SPACE, ACK.
  - IDLE: if sw_req=1, latch sw_addr/sw_data into staging registers, go to COMMIT.
  - COMMIT, sw_addr >= NUM_REGS: set addr_err, no register write, no push, go to ACK.
  - COMMIT, address valid: write register at this edge. Push command if FIFO can accept, then go to ACK. If it cannot accept and BLOCKING=1, go to WAIT_SPACE. If it cannot accept and BLOCKING=0, increment overflow_cnt (saturating) and go to ACK.
  - WAIT_SPACE: push when FIFO can accept, go to ACK. The register is not rewritten.
  - ACK: hw_ack=1 (registered, equal to state==ACK). When sw_req=0, go to IDLE; hw_ack drops the following cycle.
- Latency: sw_req sampled high at edge 0; register visible on regs_flat after edge 1; hw_ack high after edge 2; FIFO entry visible (out_valid=1) after edge 1 when space is available.
- "Can accept" means !full, or full with a pop in the same cycle (out_valid & out_ready). Simultaneous push and pop keeps fifo_level unchanged.
- FIFO: first-word-fall-through. out_addr/out_data show the head whenever out_valid=1. Pop happens on out_valid & out_ready. Read/write pointers wrap modulo FIFO_DEPTH. out_ready while empty has no effect.
- sw_addr: only the low clog2(NUM_REGS) bits index the register; the range check uses all 32 bits.
- sw_req held high after ACK causes no second commit; a new transaction needs sw_req 1→0→1.
- err_clr in the same cycle as a new error or overflow: the error or increment wins.
- Asserting reset mid-transaction aborts the transaction. Register contents and FIFO are cleared.

Decomposition:
- Shared package sof_mailbox_pkg: state enum (IDLE, COMMIT, WAIT_SPACE, ACK), OVF_CNT_W=16 constant, clog2 helper function.
- One sub-module, sof_cmd_fifo: parametrised FWFT synchronous FIFO with width clog2(NUM_REGS)+DATA_W and depth FIFO_DEPTH. It provides full, empty, level, and same-cycle push/pop.

Test Plan:
- Basic write: addr=3, data=32'hDEADBEEF, sw_req high until hw_ack → reg 3 = DEADBEEF after edge 1; hw_ack=1 after edge 2; out_addr=3, out_data=DEADBEEF, out_valid=1; drop sw_req → hw_ack=0 two edges later.
- Bad address: addr=8 (NUM_REGS=8), data=5 → no register changes; addr_err=1; FIFO empty; hw_ack still completes. Pulse err_clr → addr_err=0.
- Blocking full: BLOCKING=1, out_ready=0, five writes → after four, fifo_level=4; fifth write updates its register but hw_ack stays 0. Assert out_ready for one cycle → push, hw_ack=1, fifo_level=4.
- Drop mode: BLOCKING=0, out_ready=0, six writes → fifo_level=4, overflow_cnt=2, all six registers written, every handshake acked.
- Simultaneous push/pop: FIFO full, out_ready=1 during COMMIT → level stays 4, no stall, head order preserved. Also drain all entries in order across pointer wrap.
- Reset mid-transaction: assert reset_reset_n=0 while in WAIT_SPACE → hw_ack=0, regs 0, fifo_level=0 immediately (asynchronous). After release, a new write completes normally.
